// File: rtl/prbs8_checker.sv
// PRBS8 receive checker: hunts for the x^8+x^3 style generator sequence, flywheels once locked.
// Optional macro PRBS8_CHECKER_ZERO_DETECT_EN treats an all-zero word as a mismatch and never seeds from it.
module prbs8_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [8:1]  data_in,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

  function automatic logic [8:1] prbs_next(input logic [8:1] x);
    prbs_next = {x[7:1], x[8] ^ x[3]};
  endfunction

  logic [0:0]  state_q, state_d;
  logic [8:1]  expected_q, expected_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic        err_pulse_q, err_pulse_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        zero_s;
  logic        match_s;

`ifdef PRBS8_CHECKER_ZERO_DETECT_EN
  assign zero_s = (data_in == 8'h00);
`else
  assign zero_s = 1'b0;
`endif

  assign match_s = (data_in == expected_q) && !zero_s;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (valid) begin
      case (state_q)
        HUNT: begin
          // A zero word can never seed the hunt when zero detection is enabled.
          expected_d = zero_s ? expected_q : prbs_next(data_in);
          if (match_s) begin
            if (match_cnt_q == LOCK_LAST) begin
              state_d     = LOCKED;
              match_cnt_d = 4'd0;
              bad_cnt_d   = 4'd0;
            end else begin
              match_cnt_d = match_cnt_q + 4'd1;
            end
          end else begin
            match_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          expected_d = prbs_next(expected_q);
          if (match_s) begin
            bad_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
            if (bad_cnt_q == UNLOCK_LAST) begin
              state_d     = HUNT;
              match_cnt_d = 4'd0;
              bad_cnt_d   = 4'd0;
              expected_d  = zero_s ? prbs_next(expected_q) : prbs_next(data_in);
            end else begin
              bad_cnt_d = bad_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d     = HUNT;
          match_cnt_d = 4'd0;
          bad_cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (clr_cnt) begin
      err_cnt_d = 16'd0;
    end else begin
      err_cnt_d = err_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      expected_q  <= 8'h02;
      match_cnt_q <= 4'd0;
      bad_cnt_q   <= 4'd0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: vector table plus hand-written reset, zero-stream and saturation sequences.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_a = 1'b0, clr_a = 1'b0;
  logic [8:1]  data_a = 8'h00;
  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic        valid_b = 1'b0, clr_b = 1'b0;
  logic [8:1]  data_b = 8'h00;
  logic        locked_b, pulse_b;
  logic [15:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3)) dut_a (
    .clk(clk), .rst(rst), .valid(valid_a), .data_in(data_a), .clr_cnt(clr_a),
    .locked(locked_a), .err_pulse(pulse_a), .err_cnt(cnt_a)
  );

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15)) dut_b (
    .clk(clk), .rst(rst), .valid(valid_b), .data_in(data_b), .clr_cnt(clr_b),
    .locked(locked_b), .err_pulse(pulse_b), .err_cnt(cnt_b)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic        el;
    logic        ep;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    valid_a = v; data_a = d; clr_a = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    valid_b = v; data_b = d; clr_b = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] gen_next(input logic [7:0] x);
    gen_next = {x[6:0], x[7] ^ x[2]};
  endfunction

  initial begin
    logic [7:0] g;
    int mism;
    int run;

    // valid, data, clr, locked, pulse, count
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 8'h24, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[9]  = '{1'b1, 8'h92, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 8'h25, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[11] = '{1'b1, 8'h4B, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[12] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 16'd1};
    tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 16'd2};
    tbl[14] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'd3};
    tbl[15] = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[16] = '{1'b1, 8'h65, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[17] = '{1'b1, 8'hCB, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[18] = '{1'b1, 8'h97, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[19] = '{1'b1, 8'h2E, 1'b0, 1'b1, 1'b0, 16'd3};
    tbl[20] = '{1'b1, 8'h2E, 1'b0, 1'b1, 1'b1, 16'd4};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[22] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd1};

    repeat (2) @(negedge clk);
    chk("rst_locked", {15'd0, locked_a}, 16'd0);
    chk("rst_pulse", {15'd0, pulse_a}, 16'd0);
    chk("rst_cnt", cnt_a, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step_a(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d_locked", i), {15'd0, locked_a}, {15'd0, tbl[i].el});
      chk($sformatf("vec%0d_pulse", i), {15'd0, pulse_a}, {15'd0, tbl[i].ep});
      chk($sformatf("vec%0d_cnt", i), cnt_a, tbl[i].ec);
    end

    // Reset asserted between edges must clear outputs without waiting for a clock.
    @(negedge clk);
    valid_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked", {15'd0, locked_a}, 16'd0);
    chk("async_rst_pulse", {15'd0, pulse_a}, 16'd0);
    chk("async_rst_cnt", cnt_a, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    step_a(1'b1, 8'h01, 1'b0);
    step_a(1'b1, 8'h02, 1'b0);
    step_a(1'b1, 8'h04, 1'b0);
    step_a(1'b1, 8'h09, 1'b0);
    chk("relock_early", {15'd0, locked_a}, 16'd0);
    step_a(1'b1, 8'h12, 1'b0);
    chk("relock_after_rst", {15'd0, locked_a}, 16'd1);
    chk("relock_cnt", cnt_a, 16'd0);

    do_reset();
    for (int i = 0; i < 10; i++) step_a(1'b1, 8'h00, 1'b0);
`ifdef PRBS8_CHECKER_ZERO_DETECT_EN
    chk("zero_stream_locked", {15'd0, locked_a}, 16'd0);
    chk("zero_stream_cnt", cnt_a, 16'd0);
    step_a(1'b1, 8'h02, 1'b0);
    step_a(1'b1, 8'h04, 1'b0);
    step_a(1'b1, 8'h09, 1'b0);
    chk("zero_hold_early", {15'd0, locked_a}, 16'd0);
    step_a(1'b1, 8'h12, 1'b0);
    chk("zero_hold_lock", {15'd0, locked_a}, 16'd1);
`else
    chk("zero_stream_locked", {15'd0, locked_a}, 16'd1);
    chk("zero_stream_cnt", cnt_a, 16'd0);
`endif

    // Saturation on the wide-tolerance instance: one clean word every 15 to stay locked.
    do_reset();
    step_b(1'b1, 8'h01, 1'b0);
    step_b(1'b1, 8'h02, 1'b0);
    step_b(1'b1, 8'h04, 1'b0);
    step_b(1'b1, 8'h09, 1'b0);
    step_b(1'b1, 8'h12, 1'b0);
    chk("sat_lock", {15'd0, locked_b}, 16'd1);
    g = 8'h24;
    mism = 0;
    run = 0;
    while (mism < 65537) begin
      if (run == 14) begin
        step_b(1'b1, g, 1'b0);
        run = 0;
      end else begin
        step_b(1'b1, ~g, 1'b0);
        run++;
        mism++;
        if (mism == 65535) chk("sat_reach", cnt_b, 16'hFFFF);
      end
      g = gen_next(g);
    end
    chk("sat_hold", cnt_b, 16'hFFFF);
    chk("sat_locked", {15'd0, locked_b}, 16'd1);
    if (run == 14) begin
      step_b(1'b1, g, 1'b0);
      g = gen_next(g);
    end
    step_b(1'b1, ~g, 1'b1);
    chk("clr_priority_cnt", cnt_b, 16'd0);
    chk("clr_priority_pulse", {15'd0, pulse_b}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
